seq_addsub_unit: RTL and testbench
==================================

Name: seq_addsub_unit

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor; successor to the 1-bit add/sub cell.
- Processes a WIDTH-bit operand pair CHUNK bits per cycle, LSB first, through a registered carry chain.
- start/busy/done handshake; result and status flags held until the next operation.
- Sits between the operand register file and the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK, range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- mode  input  1  0 = add (a+b), 1 = subtract (a-b)
- a  input  WIDTH  operand A, sampled at accept
- b  input  WIDTH  operand B, sampled at accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  sum or difference
- carry_out  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned)
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0; internal operand, carry and chunk counter cleared.
- States: IDLE, RUN, DONE.
- Accept: start=1 while busy=0 (IDLE or DONE) at edge E0.
  - Latch a, mode, and b XOR {WIDTH{mode}}.
  - Carry register <= mode; chunk index <= 0; go to RUN.
  - busy=1 and done=0 from E0.
- RUN: at each edge, add chunk[index] of a and of modified b plus the carry register.
  - Write the CHUNK sum bits into the result shift/slice register; update the carry; increment the index.
  - On the last chunk (edge E0+NCHUNK): go to DONE and update the flags.
  - carry_out = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = (final result == 0).
- DONE: lasts exactly one cycle; done=1, busy=0; then IDLE unless a new start is accepted that edge.
- Latency: done asserted NCHUNK cycles after the accept edge; back-to-back throughput is one operation per NCHUNK+1 cycles.
- result is not guaranteed stable during RUN (it may show partial chunks). It is valid from done until the next accept.
- Flags hold their values until the next completion. They are not cleared at accept.
- start while busy=1: ignored; operands and mode are not resampled.
- mode and operand changes after accept have no effect.
- Reset mid-operation: immediate return to the reset state; no done pulse.
- CHUNK = WIDTH: single RUN cycle; done one cycle after accept.
- Arithmetic is modulo 2^WIDTH. Operands are interpreted as both unsigned (carry_out) and signed (overflow) simultaneously.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when overflow=1 at completion, result is clamped.
  - Positive overflow (both effective operands have MSB 0) gives 2^(WIDTH-1)-1.
  - Negative overflow gives -2^(WIDTH-1).
  - overflow, carry_out and zero reflect the unclamped computation, except zero, which is evaluated on the clamped result (never 1 after clamping).
  - No added latency.
- Undefined: wrap-around result only; no clamp logic present.

Test Plan:
- All cases use WIDTH=16, CHUNK=4.
- Add, a=0x1234, b=0x0FCC, mode=0 -> done 4 cycles after accept; result=0x2200, carry_out=0, overflow=0, zero=0.
- Subtract, a=0x0005, b=0x0007, mode=1 -> result=0xFFFE, carry_out=0 (borrow), overflow=0, zero=0.
- Add, a=0x7FFF, b=0x0001 -> result=0x8000, overflow=1, carry_out=0; with ADDSUB_SATURATE_EN, result=0x7FFF.
- Subtract, a=0x8000, b=0x0001 -> result=0x7FFF, overflow=1, carry_out=1; with ADDSUB_SATURATE_EN, result=0x8000.
- Subtract, a=0xABCD, b=0xABCD -> result=0x0000, zero=1, carry_out=1, overflow=0. Then a new start in the DONE cycle (a=1, b=2, add) -> accepted; result=0x0003 after 4 more cycles.
- Handshake and reset:
  - start pulsed 2 cycles after accept with different operands -> ignored; first result delivered unchanged.
  - rst_n low 2 cycles after accept -> all outputs 0 immediately; no done pulse follows.

Source files
------------

// File: rtl/seq_addsub_unit.sv
// Multi-cycle signed/unsigned adder-subtractor, CHUNK bits per cycle, LSB first.
// Latency: done pulses NCHUNK cycles after the accept edge; one op per NCHUNK+1 cycles.
// Backpressure: start is accepted only while busy=0; start during RUN is ignored.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   start, mode, a, b      request, 0=add / 1=subtract, operands (sampled at accept)
//   busy, done             operation in progress, one-cycle completion pulse
//   result                 sum/difference, valid from done until the next accept
//   carry_out, overflow,   final carry (subtract: 1 = no borrow), signed overflow,
//   zero                   result==0; flags hold until the next completion
//
// Optional build macro ADDSUB_SATURATE_EN: clamps result on signed overflow.
module seq_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // b already inverted for subtract
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx;
  logic             co_q;
  logic             ov_q;
  logic             zero_q;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_chk;
  logic [CHUNK-1:0] b_chk;
  logic [CHUNK:0]   chk_sum;
  logic             msb_cin;
  logic             ov_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] res_final;

  assign accept = start && (state != S_RUN);
  assign last   = (idx == IDXW'(NCHUNK - 1));

  always_comb begin
    a_chk    = a_q[int'(idx) * CHUNK +: CHUNK];
    b_chk    = b_q[int'(idx) * CHUNK +: CHUNK];
    chk_sum  = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry_q};
    // The sum bit at the MSB is a^b^cin, so the carry into the MSB falls out
    // of the chunk sum without a second adder.
    msb_cin  = chk_sum[CHUNK-1] ^ a_chk[CHUNK-1] ^ b_chk[CHUNK-1];
    ov_next  = msb_cin ^ chk_sum[CHUNK];
    res_next = res_q;
    res_next[int'(idx) * CHUNK +: CHUNK] = chk_sum[CHUNK-1:0];
`ifdef ADDSUB_SATURATE_EN
    // On overflow both effective operands share a sign; a's MSB picks the rail.
    if (ov_next) begin
      res_final = a_chk[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_final = res_next;
    end
`else
    res_final = res_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state   <= S_RUN;
            a_q     <= a;
            b_q     <= b ^ {WIDTH{mode}};
            carry_q <= mode;   // +1 completes the two's-complement negate
            idx     <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          carry_q <= chk_sum[CHUNK];
          if (last) begin
            state  <= S_DONE;
            idx    <= '0;
            res_q  <= res_final;
            co_q   <= chk_sum[CHUNK];
            ov_q   <= ov_next;
            zero_q <= (res_final == '0);
          end else begin
            idx   <= idx + IDXW'(1);
            res_q <= res_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign result    = res_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
module tb_seq_addsub_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int checks   = 0;
  int failures = 0;

`ifdef ADDSUB_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  seq_addsub_unit #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller must be at a negedge. Drives the request, which the next posedge
  // accepts, then waits (bounded) for done and checks latency and outputs.
  // glitch=1 pulses start with other operands 2 cycles after accept.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tm, input bit glitch, input logic [15:0] er,
                        input logic ec, input logic eo, input logic ez);
    int  lat;
    bit  seen;
    seen  = 1'b0;
    lat   = 0;
    start = 1'b1; a = ta; b = tb_v; mode = tm;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0; a = 16'h5A5A; b = 16'h3C3C; mode = ~tm;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
      if (glitch && cyc == 2) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; mode = 1'b0;
      end
      if (glitch && cyc == 3) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat  = cyc - 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, lat, 32'd4);
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({tag, "_result"}, {16'd0, result}, {16'd0, er});
      chk({tag, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
      chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    end
  endtask

  initial begin
    bit done_after_rst;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add1", 16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("hold_result", {16'd0, result}, 32'h2200);

    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_op("add_povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
           SAT_EN ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    run_op("sub_novf", 16'h8000, 16'h0001, 1'b1, 1'b0,
           SAT_EN ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    run_op("sub_zero", 16'hABCD, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    // Still in the DONE cycle: the next request is accepted back-to-back.
    run_op("b2b_add", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    run_op("ignore_start", 16'h1234, 16'h0FCC, 1'b0, 1'b1, 16'h2200, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ignore_no_second", {31'd0, busy | done}, 32'd0);

    // Reset two cycles into an operation.
    run_op("pre_rst", 16'h8000, 16'h0001, 1'b1, 1'b0,
           SAT_EN ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_after_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) done_after_rst = 1'b1;
    end
    chk("midrst_no_done", {31'd0, done_after_rst}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
